// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT sequencer and its butterfly.
package fft8_pkg;

  localparam int FFT_DW = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_e;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // round(cos(pi/4) * 2^(dw-1)) using scaled integer arithmetic
  function automatic longint twiddleC(input int dw);
    return (64'sd70710678 * (64'sd1 <<< (dw - 1)) + 64'sd50000000) / 64'sd100000000;
  endfunction

  localparam logic [FFT_DW-1:0] TW_C = FFT_DW'(twiddleC(FFT_DW));

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_bfly.sv
// Combinational radix-2 butterfly with the four 8-point twiddles and a
// built-in divide-by-two so three stages scale the result by 1/8.
module fft8_bfly
  import fft8_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic [DW-1:0] topRe_i,
  input  logic [DW-1:0] topIm_i,
  input  logic [DW-1:0] botRe_i,
  input  logic [DW-1:0] botIm_i,
  input  logic [1:0]    tw_i,
  output logic [DW-1:0] topRe_o,
  output logic [DW-1:0] topIm_o,
  output logic [DW-1:0] botRe_o,
  output logic [DW-1:0] botIm_o
);

  localparam logic signed [DW-1:0] C     = DW'(twiddleC(DW));
  localparam logic signed [DW-1:0] NEG_C = -C;

  logic signed [DW-1:0]   bRe, bIm, tRe, tIm;
  logic signed [DW-1:0]   wRe, wIm;
  logic signed [2*DW-1:0] mRR, mII, mRI, mIR;
  logic signed [DW-1:0]   sRR, sII, sRI, sIR;
  logic signed [DW:0]     pRe, pIm;
  logic signed [DW:0]     sumRe, sumIm, difRe, difIm;

  assign bRe = botRe_i;
  assign bIm = botIm_i;
  assign tRe = topRe_i;
  assign tIm = topIm_i;

  // W1 = (C, -C) and W3 = (-C, -C); the imaginary part is -C for both
  always_comb begin
    wIm = NEG_C;
    wRe = (tw_i == 2'd3) ? NEG_C : C;
  end

  assign mRR = bRe * wRe;
  assign mII = bIm * wIm;
  assign mRI = bRe * wIm;
  assign mIR = bIm * wRe;

  assign sRR = DW'(mRR >>> (DW - 1));
  assign sII = DW'(mII >>> (DW - 1));
  assign sRI = DW'(mRI >>> (DW - 1));
  assign sIR = DW'(mIR >>> (DW - 1));

  always_comb begin
    pRe = {bRe[DW-1], bRe};
    pIm = {bIm[DW-1], bIm};
    case (tw_i)
      2'd0: begin
        pRe = {bRe[DW-1], bRe};
        pIm = {bIm[DW-1], bIm};
      end
      2'd2: begin
        pRe = {bIm[DW-1], bIm};
        pIm = -{bRe[DW-1], bRe};
      end
      default: begin
        pRe = {sRR[DW-1], sRR} - {sII[DW-1], sII};
        pIm = {sRI[DW-1], sRI} + {sIR[DW-1], sIR};
      end
    endcase
  end

  assign sumRe = {tRe[DW-1], tRe} + pRe;
  assign sumIm = {tIm[DW-1], tIm} + pIm;
  assign difRe = {tRe[DW-1], tRe} - pRe;
  assign difIm = {tIm[DW-1], tIm} - pIm;

  assign topRe_o = DW'(sumRe >>> 1);
  assign topIm_o = DW'(sumIm >>> 1);
  assign botRe_o = DW'(difRe >>> 1);
  assign botIm_o = DW'(difIm >>> 1);

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Load / compute / unload sequencer for an in-place 8-point DIT FFT that
// time-shares one butterfly across all 12 butterfly operations.
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_real_i,
  input  logic [DW-1:0] in_imag_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_real_o,
  output logic [DW-1:0] out_imag_o,
  output logic [2:0]    out_idx_o,
  output logic          busy_o
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  stage_q, stage_d;
  logic [1:0]  bfly_q, bfly_d;
  logic        loadWe, bflyWe;

  logic [DW-1:0] bufRe_q [8];
  logic [DW-1:0] bufIm_q [8];

  logic [2:0]    topIdx, botIdx, rdIdx;
  logic [1:0]    twIdx;
  logic [DW-1:0] nTopRe, nTopIm, nBotRe, nBotIm;

  // Butterfly pairing: span h = 1<<stage, twiddle index j<<(2-stage)
  always_comb begin
    case (stage_q)
      2'd0: begin
        topIdx = {bfly_q, 1'b0};
        botIdx = {bfly_q, 1'b1};
        twIdx  = 2'd0;
      end
      2'd1: begin
        topIdx = {bfly_q[1], 1'b0, bfly_q[0]};
        botIdx = {bfly_q[1], 1'b1, bfly_q[0]};
        twIdx  = {bfly_q[0], 1'b0};
      end
      default: begin
        topIdx = {1'b0, bfly_q};
        botIdx = {1'b1, bfly_q};
        twIdx  = bfly_q;
      end
    endcase
  end

  fft8_bfly #(.DW(DW)) uBfly (
    .topRe_i (bufRe_q[topIdx]),
    .topIm_i (bufIm_q[topIdx]),
    .botRe_i (bufRe_q[botIdx]),
    .botIm_i (bufIm_q[botIdx]),
    .tw_i    (twIdx),
    .topRe_o (nTopRe),
    .topIm_o (nTopIm),
    .botRe_o (nBotRe),
    .botIm_o (nBotIm)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    loadWe      = 1'b0;
    bflyWe      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          loadWe = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        busy_o = 1'b1;
        bflyWe = 1'b1;
        bfly_d = bfly_q + 2'd1;
        if (bfly_q == 2'd3) begin
          if (stage_q == 2'd2) begin
            stage_d = 2'd0;
            state_d = ST_UNLOAD;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      ST_UNLOAD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= 3'd0;
      stage_q <= 2'd0;
      bfly_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  // Samples land in bit-reversed slots so the stages can run in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        bufRe_q[i] <= '0;
        bufIm_q[i] <= '0;
      end
    end else if (loadWe) begin
      bufRe_q[bitrev3(cnt_q)] <= in_real_i;
      bufIm_q[bitrev3(cnt_q)] <= in_imag_i;
    end else if (bflyWe) begin
      bufRe_q[topIdx] <= nTopRe;
      bufIm_q[topIdx] <= nTopIm;
      bufRe_q[botIdx] <= nBotRe;
      bufIm_q[botIdx] <= nBotIm;
    end
  end

  assign rdIdx      = (state_q == ST_UNLOAD) ? cnt_q : 3'd0;
  assign out_idx_o  = rdIdx;
  assign out_real_o = bufRe_q[rdIdx];
  assign out_imag_o = bufIm_q[rdIdx];

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Self-checking bench for fft8_seq_ctrl: directed spectra, random frames with
// backpressure against a behavioural FFT model, and reset during compute.
module tb_fft8_seq_ctrl;
  import fft8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_real_i = '0;
  logic [15:0] in_imag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_real_o;
  logic [15:0] out_imag_o;
  logic [2:0]  out_idx_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  fft8_seq_ctrl #(.DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_real_i   (in_real_i),
    .in_imag_i   (in_imag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_real_o  (out_real_o),
    .out_imag_o  (out_imag_o),
    .out_idx_o   (out_idx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int bitrev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  function automatic int scaleMul(input longint a, input longint w);
    return wrap16((a * w) >>> 15);
  endfunction

  // Reference: bit-reversed load, then the 12 scaled butterflies in order
  task automatic fftModel(input cplx_t xs[8], output int yr[8], output int yi[8]);
    longint ar[8], ai[8];
    longint pr, pi, wr, wi, tr, ti;
    int h, j, top, bot, t, c;
    c = int'(TW_C);
    for (int n = 0; n < 8; n++) begin
      ar[bitrev(n)] = longint'(xs[n].re);
      ai[bitrev(n)] = longint'(xs[n].im);
    end
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++) begin
        h = 1 << s;
        j = b % h;
        top = (b / h) * 2 * h + j;
        bot = top + h;
        t = j * (4 >> s);
        if (t == 0) begin
          pr = ar[bot];
          pi = ai[bot];
        end else if (t == 2) begin
          pr = ai[bot];
          pi = -ar[bot];
        end else begin
          wr = (t == 1) ? c : -c;
          wi = -c;
          pr = scaleMul(ar[bot], wr) - scaleMul(ai[bot], wi);
          pi = scaleMul(ar[bot], wi) + scaleMul(ai[bot], wr);
        end
        tr = ar[top];
        ti = ai[top];
        ar[top] = wrap16((tr + pr) >>> 1);
        ai[top] = wrap16((ti + pi) >>> 1);
        ar[bot] = wrap16((tr - pr) >>> 1);
        ai[bot] = wrap16((ti - pi) >>> 1);
      end
    end
    for (int k = 0; k < 8; k++) begin
      yr[k] = int'(ar[k]);
      yi[k] = int'(ai[k]);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_out_idx"}, 32'(out_idx_o), 32'd0);
    checkOutput({tag, "_out_real"}, 32'(out_real_o), 32'd0);
    checkOutput({tag, "_out_imag"}, 32'(out_imag_o), 32'd0);
  endtask

  // One frame: load, time compute, unload; abortAt > 0 resets in compute
  task automatic applyStimulus(input cplx_t xs[8], input int er[8], input int ei[8],
                               input int inGap, input int outGap, input bit holdValid,
                               input int abortAt);
    int n, k, cyc, lat, busyCnt;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checkOutput("load_in_ready", 32'(in_ready_o), 32'd1);
      checkOutput("load_out_valid", 32'(out_valid_o), 32'd0);
      in_valid_i = ($urandom_range(0, 99) >= inGap);
      in_real_i = xs[n].re;
      in_imag_i = xs[n].im;
      if (in_valid_i && in_ready_o) n++;
    end
    checkOutput("load_count", 32'(n), 32'd8);
    if (n < 8) return;

    lat = 0;
    busyCnt = 0;
    while (!out_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy_o) busyCnt++;
      checkOutput("no_accept_busy", 32'(in_ready_o), 32'd0);
      in_valid_i = holdValid ? 1'b1 : 1'($urandom_range(0, 1));
      in_real_i = 16'($urandom);
      in_imag_i = 16'($urandom);
      if (abortAt > 0 && busyCnt == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkReset("midrst");
        in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    checkOutput("busy_cycles", 32'(busyCnt), 32'd12);
    checkOutput("ovalid_latency", 32'(lat), 32'd13);
    if (!out_valid_o) return;

    k = 0;
    for (cyc = 0; k < 8 && cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput("unload_valid", 32'(out_valid_o), 32'd1);
      checkOutput("unload_in_ready", 32'(in_ready_o), 32'd0);
      checkOutput("unload_idx", 32'(out_idx_o), 32'(k));
      checkOutput("bin_real", 32'(out_real_o), 32'(er[k][15:0]));
      checkOutput("bin_imag", 32'(out_imag_o), 32'(ei[k][15:0]));
      out_ready_i = ($urandom_range(0, 99) >= outGap);
      in_valid_i = holdValid ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_ready_i) k++;
    end
    checkOutput("unload_count", 32'(k), 32'd8);
    @(negedge clk);
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    checkOutput("back_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("back_out_valid", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    cplx_t xs[8];
    int er[8], ei[8];

    repeat (2) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;

    // Impulse
    for (int i = 0; i < 8; i++) begin
      xs[i] = '0;
      er[i] = 'h0800;
      ei[i] = 0;
    end
    xs[0].re = 16'h4000;
    applyStimulus(xs, er, ei, 0, 0, 1'b0, 0);

    // DC
    for (int i = 0; i < 8; i++) begin
      xs[i].re = 16'h4000;
      xs[i].im = '0;
      er[i] = 0;
      ei[i] = 0;
    end
    er[0] = 'h4000;
    applyStimulus(xs, er, ei, 0, 0, 1'b0, 0);

    // Nyquist
    for (int i = 0; i < 8; i++) begin
      xs[i].re = (i % 2 == 0) ? 16'h4000 : 16'hC000;
      xs[i].im = '0;
      er[i] = 0;
      ei[i] = 0;
    end
    er[4] = 'h4000;
    applyStimulus(xs, er, ei, 0, 0, 1'b0, 0);

    // Shifted impulse: bins 0, 2, 6 pinned to known values
    for (int i = 0; i < 8; i++) xs[i] = '0;
    xs[1].re = 16'h4000;
    fftModel(xs, er, ei);
    er[0] = 'h0800;
    ei[0] = 0;
    er[2] = 0;
    ei[2] = 'hF800;
    er[6] = 0;
    ei[6] = 'h0800;
    applyStimulus(xs, er, ei, 0, 0, 1'b0, 0);

    // Random frames under backpressure with in_valid held outside LOAD
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        xs[i].re = 16'($urandom);
        xs[i].im = 16'($urandom);
      end
      fftModel(xs, er, ei);
      applyStimulus(xs, er, ei, 40, 40, 1'b1, 0);
    end

    // Reset at compute cycle 5, then a clean frame
    for (int i = 0; i < 8; i++) begin
      xs[i].re = 16'($urandom);
      xs[i].im = 16'($urandom);
    end
    fftModel(xs, er, ei);
    applyStimulus(xs, er, ei, 0, 0, 1'b1, 5);
    for (int i = 0; i < 8; i++) begin
      xs[i].re = 16'($urandom);
      xs[i].im = 16'($urandom);
    end
    fftModel(xs, er, ei);
    applyStimulus(xs, er, ei, 20, 30, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
